// File: rtl/lcd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_cmd_arbiter
//
// Shares one LCD controller among NREQ command sources. Pending requests are
// arbitrated round-robin. Each winner is issued as a one-cycle lcd_enable
// strobe together with its {rs, rw, data[7:0]} word on lcd_bus. The arbiter
// then waits for the controller to acknowledge with lcd_busy and enforces a
// minimum hold-off before the next command may be launched.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-source request level, held until the matching gnt
//   cmd         per-source command word, source i at [10i+9:10i]
//   gnt         one-hot pulse: command of that source accepted
//   done        one-hot pulse: command of that source completed or timed out
//   lcd_busy    busy flag from the LCD controller
//   lcd_enable  one-cycle command strobe to the LCD controller
//   lcd_bus     registered command word to the LCD controller
//   arb_busy    high whenever the arbiter is not idle
//   ack_err     sticky flag: an issued command never saw lcd_busy rise
//   err_clr     synchronous clear of ack_err
// ---------------------------------------------------------------------------
module lcd_cmd_arbiter #(
   parameter int NREQ        = 4,
   parameter int HOLDOFF     = 9000,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [10*NREQ-1:0] cmd,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   input  logic               lcd_busy,
   output logic               lcd_enable,
   output logic [9:0]         lcd_bus,
   output logic               arb_busy,
   output logic               ack_err,
   input  logic               err_clr
);

   localparam int CMAX = (HOLDOFF > ACK_TIMEOUT) ? HOLDOFF : ACK_TIMEOUT;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int PW   = $clog2(NREQ);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);
   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_SRC  = PW'(NREQ - 1);
   localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [PW-1:0]   win, win_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [NREQ-1:0] gnt_n, done_n;
   logic            en_n;
   logic [9:0]      bus_n;
   logic            err_n;

   logic [PW-1:0]   pick;
   logic            found;
   logic [PW:0]     idx_w;
   logic [PW-1:0]   win_inc;
   logic [9:0]      cmd_arr [NREQ];

   // Unpack the flat command bus so the winner's word can be selected by index
   for (genvar i = 0; i < NREQ; i++) begin : g_cmd
      assign cmd_arr[i] = cmd[10*i +: 10];
   end

   // Round-robin scan: first asserted request at or above ptr, wrapping at NREQ.
   // The sum ptr+k is kept one bit wider so the wrap compare cannot overflow.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx_w = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, ptr} + (PW+1)'(k);
         if (idx_w >= NREQ_W) begin
            idx_w = idx_w - NREQ_W;
         end
         if (!found && req[idx_w[PW-1:0]]) begin
            found = 1'b1;
            pick  = idx_w[PW-1:0];
         end
      end
   end

   // After a command finishes the pointer moves just past its source, so that
   // source has lowest priority in the next round.
   assign win_inc = (win == LAST_SRC) ? '0 : win + 1'b1;

   assign arb_busy = (state != IDLE);

   // Next-state and next-output logic. Every output is registered, so this
   // block computes the values loaded on the coming edge.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      win_n   = win;
      cnt_n   = cnt;
      gnt_n   = '0;
      done_n  = '0;
      en_n    = 1'b0;
      bus_n   = lcd_bus;
      err_n   = err_clr ? 1'b0 : ack_err;

      case (state)
         IDLE: begin
            if (!lcd_busy && found) begin
               bus_n       = cmd_arr[pick];
               en_n        = 1'b1;
               gnt_n[pick] = 1'b1;
               win_n       = pick;
               cnt_n       = '0;
               state_n     = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            if (lcd_busy) begin
               cnt_n   = '0;
               state_n = HOLD;
            end else if (cnt == ACK_LAST) begin
               // A timeout setting the flag takes precedence over err_clr
               err_n       = 1'b1;
               done_n[win] = 1'b1;
               ptr_n       = win_inc;
               state_n     = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         HOLD: begin
            // Counter saturates at the last hold-off cycle; release waits for
            // both the hold-off and the controller going idle.
            if (cnt == HOLD_LAST) begin
               if (!lcd_busy) begin
                  done_n[win] = 1'b1;
                  ptr_n       = win_inc;
                  state_n     = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any command in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         win        <= '0;
         cnt        <= '0;
         gnt        <= '0;
         done       <= '0;
         lcd_enable <= 1'b0;
         lcd_bus    <= '0;
         ack_err    <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         win        <= win_n;
         cnt        <= cnt_n;
         gnt        <= gnt_n;
         done       <= done_n;
         lcd_enable <= en_n;
         lcd_bus    <= bus_n;
         ack_err    <= err_n;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_arbiter
//
// Self-checking bench for lcd_cmd_arbiter with NREQ=4, HOLDOFF=20,
// ACK_TIMEOUT=8. A table of command transactions (request mask, command
// words, busy behaviour, expected winner/word/error flag) is applied in a
// loop, followed by hand-written sequences for busy-in-idle, request
// withdrawal and reset in the middle of a command.
//
// Timing used for expectations: inputs are driven and outputs sampled 1 time
// unit after a rising edge. When the bench raises lcd_busy right after edge
// e, the arbiter acknowledges on edge e+1 and done is registered HOLDOFF
// edges later (e+1+HOLDOFF), or on the first edge after that which sees
// lcd_busy low.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_arbiter;

   localparam int NREQ        = 4;
   localparam int HOLDOFF     = 20;
   localparam int ACK_TIMEOUT = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [10*NREQ-1:0]  cmd = '0;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic                lcd_busy = 1'b0;
   logic                lcd_enable;
   logic [9:0]          lcd_bus;
   logic                arb_busy;
   logic                ack_err;
   logic                err_clr = 1'b0;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int last_en  = 0;

   lcd_cmd_arbiter #(
      .NREQ        (NREQ),
      .HOLDOFF     (HOLDOFF),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .cmd        (cmd),
      .gnt        (gnt),
      .done       (done),
      .lcd_busy   (lcd_busy),
      .lcd_enable (lcd_enable),
      .lcd_bus    (lcd_bus),
      .arb_busy   (arb_busy),
      .ack_err    (ack_err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Pulses must be one-hot and gnt/done must never coincide
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ($countones(gnt) > 1 || $countones(done) > 1 || (|gnt && |done)) begin
            failures++;
            $display("[TB] FAIL pulse_onehot at cycle %0d: gnt=%b done=%b required one-hot, not coincident",
                     cycle, gnt, done);
         end
      end
   end

   typedef struct {
      logic [3:0]  req;
      logic [39:0] cmd;
      int          busy_len;   // cycles busy is held high; -1 means never acknowledge
      bit          keep;       // requester keeps req high after its gnt
      bit          clr_at_to;  // err_clr coincident with the timeout edge
      bit          pre_clr;    // pulse err_clr before this transaction
      bit          check_gap;  // enable spacing from previous command checked
      int          exp_win;
      logic [9:0]  exp_bus;
      logic        exp_err;
   } vec_t;

   vec_t vec [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input int i);
      vec_t       v;
      int         n;
      int         exp_n;
      bit         seen;
      bit         bad_arb;
      bit         bad_gnt;
      logic [3:0] oh;
      v       = vec[i];
      oh      = 4'b0001 << v.exp_win;
      bad_arb = 1'b0;
      bad_gnt = 1'b0;

      if (v.pre_clr) begin
         req     = '0;
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         check_output("err_clr_clears", {31'd0, ack_err}, 32'd0);
      end

      req  = v.req;
      cmd  = v.cmd;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         if (gnt != '0) seen = 1'b1;
      end
      check_output($sformatf("vec%0d_grant_seen", i), {31'd0, seen}, 32'd1);
      if (!seen) return;

      check_output($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, oh});
      check_output($sformatf("vec%0d_enable", i), {31'd0, lcd_enable}, 32'd1);
      check_output($sformatf("vec%0d_bus", i), {22'd0, lcd_bus}, {22'd0, v.exp_bus});
      if (v.check_gap) begin
         check_output($sformatf("vec%0d_enable_gap_ge22", i), {31'd0, (cycle - last_en) >= 22}, 32'd1);
      end
      last_en = cycle;
      if (!v.keep) req[v.exp_win] = 1'b0;

      seen = 1'b0;
      n    = 0;
      if (v.busy_len > 0) begin
         tick();
         check_output($sformatf("vec%0d_enable_drop", i), {31'd0, lcd_enable}, 32'd0);
         lcd_busy = 1'b1;
         while (!seen && n < 100) begin
            tick();
            n++;
            if (n == v.busy_len) lcd_busy = 1'b0;
            if (done != '0) seen = 1'b1;
            else begin
               if (!arb_busy) bad_arb = 1'b1;
               if (gnt != '0) bad_gnt = 1'b1;
            end
         end
         lcd_busy = 1'b0;
         exp_n = (v.busy_len + 1 > HOLDOFF + 1) ? v.busy_len + 1 : HOLDOFF + 1;
      end else begin
         while (!seen && n < 100) begin
            tick();
            n++;
            err_clr = v.clr_at_to && (n == ACK_TIMEOUT - 1);
            if (done != '0) seen = 1'b1;
            else begin
               if (!arb_busy) bad_arb = 1'b1;
               if (gnt != '0) bad_gnt = 1'b1;
            end
         end
         err_clr = 1'b0;
         exp_n = ACK_TIMEOUT;
      end

      check_output($sformatf("vec%0d_done_latency", i), n, exp_n);
      check_output($sformatf("vec%0d_done", i), {28'd0, done}, {28'd0, oh});
      check_output($sformatf("vec%0d_ack_err", i), {31'd0, ack_err}, {31'd0, v.exp_err});
      check_output($sformatf("vec%0d_idle_after_done", i), {31'd0, arb_busy}, 32'd0);
      check_output($sformatf("vec%0d_bus_held", i), {22'd0, lcd_bus}, {22'd0, v.exp_bus});
      check_output($sformatf("vec%0d_arb_busy_during", i), {31'd0, bad_arb}, 32'd0);
      check_output($sformatf("vec%0d_no_gnt_during", i), {31'd0, bad_gnt}, 32'd0);
   endtask

   initial begin : main
      logic [39:0] ca;
      logic [39:0] cb;
      bit          bad;
      bit          seen;
      ca = {10'h3C3, 10'h155, 10'h0AA, 10'h2E1};
      cb = {10'h3C3, 10'h155, 10'h0AA, 10'h230};

      //           req      cmd busy keep clr  pre  gap  win bus      err
      vec[0] = '{4'b1111, ca,  3,  1,   0,   0,   0,   0,  10'h2E1, 1'b0};
      vec[1] = '{4'b1111, ca,  3,  1,   0,   0,   1,   1,  10'h0AA, 1'b0};
      vec[2] = '{4'b1111, ca,  3,  1,   0,   0,   1,   2,  10'h155, 1'b0};
      vec[3] = '{4'b1111, ca,  3,  1,   0,   0,   1,   3,  10'h3C3, 1'b0};
      vec[4] = '{4'b1111, ca,  3,  1,   0,   0,   1,   0,  10'h2E1, 1'b0};
      vec[5] = '{4'b0001, cb,  3,  0,   0,   0,   0,   0,  10'h230, 1'b0};
      vec[6] = '{4'b0010, cb, -1,  0,   0,   0,   0,   1,  10'h0AA, 1'b1};
      vec[7] = '{4'b1111, cb,  3,  0,   0,   0,   0,   2,  10'h155, 1'b1};
      vec[8] = '{4'b1001, cb, -1,  0,   1,   1,   0,   3,  10'h3C3, 1'b1};
      vec[9] = '{4'b0101, cb, 40,  0,   0,   0,   0,   0,  10'h230, 1'b1};

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check_output("reset_outputs", {14'd0, gnt, done, lcd_enable, lcd_bus, arb_busy, ack_err},
                   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check_output("reset_release_idle", {22'd0, gnt, done, lcd_enable, arb_busy}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(i);
      end

      // Busy in idle blocks the grant; ptr is 1 here, only req[2] pending
      lcd_busy = 1'b1;
      req      = 4'b0100;
      bad      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (gnt != '0 || lcd_enable) bad = 1'b1;
      end
      check_output("busy_idle_no_grant", {31'd0, bad}, 32'd0);
      lcd_busy = 1'b0;
      tick();
      check_output("busy_fall_gnt2", {28'd0, gnt}, 32'h4);
      check_output("busy_fall_enable", {31'd0, lcd_enable}, 32'd1);
      req  = '0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (done != '0) seen = 1'b1;
      end
      check_output("busy_fall_done2", {28'd0, done}, 32'h4);

      // Request withdrawn while busy holds off the grant
      lcd_busy = 1'b1;
      req      = 4'b0100;
      tick();
      tick();
      req      = '0;
      lcd_busy = 1'b0;
      bad      = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (gnt != '0 || lcd_enable || done != '0) bad = 1'b1;
      end
      check_output("withdraw_no_side_effect", {31'd0, bad}, 32'd0);
      check_output("withdraw_idle", {31'd0, arb_busy}, 32'd0);

      // Reset during WAIT_ACK; ptr is 3 here so req[2] wins
      req = 4'b0100;
      tick();
      check_output("rst_pre_gnt2", {28'd0, gnt}, 32'h4);
      req = '0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_output("rst_async_outputs", {14'd0, gnt, done, lcd_enable, lcd_bus, arb_busy, ack_err},
                   32'd0);
      req = 4'b1010;
      bad = 1'b0;
      tick();
      if (done != '0 || gnt != '0) bad = 1'b1;
      tick();
      if (done != '0 || gnt != '0) bad = 1'b1;
      rst_n = 1'b1;
      check_output("rst_no_done", {31'd0, bad}, 32'd0);
      tick();
      // ptr back at 0, so source 1 wins over source 3
      check_output("rst_ptr0_gnt1", {28'd0, gnt}, 32'h2);
      check_output("rst_ptr0_bus", {22'd0, lcd_bus}, 32'h0AA);
      req  = '0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (done != '0) seen = 1'b1;
      end
      check_output("rst_after_done1", {28'd0, done}, 32'h2);
      check_output("rst_after_ack_err", {31'd0, ack_err}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_arbiter.md
Name: lcd_cmd_arbiter

Overview:
Shares a single LCD controller among NREQ command sources (status display, debug console, menu logic, ...).
- Arbitrates pending commands round-robin.
- Issues each winner as a one-cycle lcd_enable pulse with a 10-bit {rs, rw, data} word on lcd_bus.
- Tracks the controller's busy handshake and enforces a minimum per-command hold-off, so no command is launched while the previous enable cycle is still running.
- Sits between requester logic and the LCD controller's lcd_enable/lcd_bus/busy interface.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLDOFF, 9000, minimum cycles from busy-acknowledge to completion (50 us at clk_freq 180); must be >= 1
ACK_TIMEOUT, 64, cycles to wait for busy to rise after issue; must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  request level per source; held high until matching gnt
cmd  in  10*NREQ  per-source command, source i at [10i+9:10i] = {rs, rw, data[7:0]}
gnt  out  NREQ  one-hot, one-cycle pulse: command of that source accepted
done  out  NREQ  one-hot, one-cycle pulse: command of that source completed or timed out
lcd_busy  in  1  busy from LCD controller
lcd_enable  out  1  one-cycle command strobe to LCD controller
lcd_bus  out  10  command word to LCD controller, registered
arb_busy  out  1  high whenever state != IDLE
ack_err  out  1  sticky: an issued command never saw lcd_busy rise
err_clr  in  1  synchronous clear of ack_err

Behaviour:
Reset (async, rst_n=0):
- All outputs 0; state IDLE; round-robin pointer = 0; counter = 0; latched winner = 0.
- Reset mid-operation aborts the command: lcd_enable drops immediately and no done is generated.

State machine: IDLE, WAIT_ACK, HOLD.

IDLE:
- Grant condition: lcd_busy==0 and |req.
- Winner = first asserted req scanning from ptr upward, wrapping at NREQ.
- On the granting edge:
  - lcd_bus <= cmd[winner]; lcd_enable <= 1; gnt[winner] <= 1.
  - Latch winner; counter <= 0; go to WAIT_ACK.
- Latency: req/cmd sampled at edge t; lcd_enable and gnt are high during cycle t+1 only.
- If lcd_busy==1 or no req: stay in IDLE, outputs idle.

WAIT_ACK:
- lcd_enable and gnt return to 0. lcd_bus holds its value until the next grant.
- lcd_busy==1: counter <= 0; go to HOLD.
- Otherwise, at counter == ACK_TIMEOUT-1: ack_err <= 1; done[winner] pulses; ptr <= winner+1 mod NREQ; go to IDLE.
- Otherwise: counter increments.

HOLD:
- counter increments, saturating at HOLDOFF-1.
- Exit only when counter == HOLDOFF-1 and lcd_busy==0: done[winner] pulses; ptr <= winner+1 mod NREQ; go to IDLE.
- Busy still high after hold-off: remain in HOLD.
- Busy dropping early (before HOLDOFF) does not release the arbiter.

Requester rules:
- cmd is sampled only at grant and may change afterwards.
- req dropped before gnt means the request is withdrawn, with no side effects.
- A requester may re-raise req immediately after its gnt. It is considered again only after done, at lowest priority (ptr has moved past it).
- gnt and done never coincide. At most one gnt and one done per command.

Fairness: with all NREQ requesting continuously, grant order is 0,1,...,NREQ-1,0,... Worst-case wait is NREQ-1 commands.

Counter: width = clog2(max(HOLDOFF, ACK_TIMEOUT)) + 1, unsigned, never wraps.

ack_err:
- err_clr clears it synchronously.
- err_clr and a new timeout in the same cycle: set wins.

arb_busy is combinational from state.

Test Plan:
1. HOLDOFF=20, ACK_TIMEOUT=8. req=4'b0001, cmd0=10'h230, bench asserts lcd_busy 1 cycle after lcd_enable, drops it 3 cycles later -> gnt[0] and lcd_enable in the same cycle, lcd_bus=10'h230; done[0] exactly 20 cycles after busy rise; arb_busy high throughout.
2. All four req held high from reset, busy modelled as in 1 -> gnt order 0,1,2,3,0; each lcd_enable separated by >= 22 cycles; no two gnt bits ever high together.
3. lcd_busy held low after issue -> ack_err=1 and done[winner] 8 cycles after lcd_enable; next grant goes to winner+1. err_clr pulse clears ack_err. err_clr coincident with a second timeout -> ack_err stays 1.
4. lcd_busy held high through hold-off for 40 cycles -> done only on the first cycle busy is low after counter reaches 19; no grant while busy.
5. lcd_busy=1 in IDLE with req=4'b0100 -> no grant; busy falls -> gnt[2] the next edge. req[2] dropped before grant in a repeat run -> no gnt, no lcd_enable.
6. rst_n low 2 cycles after lcd_enable (in WAIT_ACK) -> outputs 0 immediately, no done; after release, pending req=4'b0010 granted with ptr=0 order.
